// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter.
//   - FSM state encodings (IDLE/RD/WR/RESP)
//   - port count and port index names (cpu = 0, debug/loader = 1)
package mem_arb_pkg;

  localparam int unsigned NPORTS = 2;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RD   = 2'd1;
  localparam state_t WR   = 2'd2;
  localparam state_t RESP = 2'd3;

  typedef logic port_idx_t;
  localparam port_idx_t P_CPU = 1'b0;
  localparam port_idx_t P_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory handshake bundle, used both for each requester port and for the RAM port.
//   rd_en    : read request, held until rd_valid
//   addr     : address, sampled with rd_en or wr_en
//   wr_en    : one-cycle write strobe
//   wr_data  : write data, sampled with wr_en
//   rd_data  : read data
//   rd_valid : one-cycle read response strobe
// master drives the request side, slave drives the response side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output rd_en, addr, wr_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, addr, wr_en, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/mem_arb_wbuf.sv
// One-entry posted-write buffer with sticky overflow flag.
//   clk, rst   : clock, asynchronous active-high reset
//   i_wr_en    : write pulse from the requester, never stalled
//   i_addr     : write address captured with i_wr_en
//   i_wr_data  : write data captured with i_wr_en
//   i_drain    : arbiter is retiring this entry in the current cycle
//   o_valid    : entry held
//   o_addr     : buffered address
//   o_data     : buffered data
//   o_ovf      : a write was dropped because the entry was occupied (sticky)
import mem_arb_pkg::*;

module mem_arb_wbuf #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_drain,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ovf
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else if (i_wr_en) begin
      // A write landing on the draining cycle replaces the retiring entry.
      if (!r_valid || i_drain) begin
        r_valid <= 1'b1;
        r_addr  <= i_addr;
        r_data  <= i_wr_data;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single RAM port (p0 = cpu, p1 = debug/loader).
// Writes are posted into a per-port one-entry buffer and always drained
// before that port's next read; one memory transaction is outstanding at a time.
//   clk, rst : clock, asynchronous active-high reset
//   p0, p1   : requester ports (slave side of mem_arbiter_if)
//   mem      : RAM port (master side of mem_arbiter_if)
//   wr_ovf   : sticky per-port write-buffer overflow, cleared only by rst
// Build option ARB_ROUND_ROBIN_EN: ties go to the port that was not granted
// last; without it p0 always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        p0,
  mem_arbiter_if.slave        p1,
  mem_arbiter_if.master       mem,
  output logic [NPORTS-1:0]   wr_ovf
);

  logic [NPORTS-1:0] w_rd_en;
  logic [NPORTS-1:0] w_wr_en;
  logic [NPORTS-1:0] w_wb_valid;
  logic [NPORTS-1:0] w_drain;
  logic [NPORTS-1:0] w_elig;
  logic [NPORTS-1:0] w_ovf;
  logic [ADDR_W-1:0] w_req_addr  [NPORTS];
  logic [DATA_W-1:0] w_req_wdata [NPORTS];
  logic [ADDR_W-1:0] w_wb_addr   [NPORTS];
  logic [DATA_W-1:0] w_wb_data   [NPORTS];
  port_idx_t         w_win;

  state_t            r_state;
  port_idx_t         r_grant;
  logic              r_mem_rd_en;
  logic              r_mem_wr_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wr_data;
  logic [DATA_W-1:0] r_rd_data  [NPORTS];
  logic [NPORTS-1:0] r_rd_valid;
`ifdef ARB_ROUND_ROBIN_EN
  port_idx_t         r_last_grant;
`endif

  assign w_rd_en = {p1.rd_en, p0.rd_en};
  assign w_wr_en = {p1.wr_en, p0.wr_en};
  assign w_req_addr[P_CPU]  = p0.addr;
  assign w_req_addr[P_DBG]  = p1.addr;
  assign w_req_wdata[P_CPU] = p0.wr_data;
  assign w_req_wdata[P_DBG] = p1.wr_data;

  for (genvar g = 0; g < NPORTS; g++) begin : g_wbuf
    assign w_drain[g] = (r_state == WR) && (r_grant == port_idx_t'(g));

    mem_arb_wbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en[g]),
      .i_addr    (w_req_addr[g]),
      .i_wr_data (w_req_wdata[g]),
      .i_drain   (w_drain[g]),
      .o_valid   (w_wb_valid[g]),
      .o_addr    (w_wb_addr[g]),
      .o_data    (w_wb_data[g]),
      .o_ovf     (w_ovf[g])
    );
  end

  // A read arriving together with a write pulse on the same port is held off
  // one cycle so the write lands in the buffer first and is drained ahead of it.
  assign w_elig = w_wb_valid | (w_rd_en & ~w_wr_en);

  always_comb begin
    w_win = P_CPU;
`ifdef ARB_ROUND_ROBIN_EN
    if (&w_elig) w_win = ~r_last_grant;
    else         w_win = w_elig[P_CPU] ? P_CPU : P_DBG;
`else
    w_win = w_elig[P_CPU] ? P_CPU : P_DBG;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= P_CPU;
      r_mem_rd_en   <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_rd_data     <= '{default: '0};
      r_rd_valid    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant  <= P_DBG;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_grant <= w_win;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= w_win;
`endif
            if (w_wb_valid[w_win]) begin
              r_mem_wr_en   <= 1'b1;
              r_mem_addr    <= w_wb_addr[w_win];
              r_mem_wr_data <= w_wb_data[w_win];
              r_state       <= WR;
            end else begin
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= w_req_addr[w_win];
              r_state     <= RD;
            end
          end
        end
        WR: begin
          r_mem_wr_en <= 1'b0;
          r_state     <= IDLE;
        end
        RD: begin
          if (mem.rd_valid) begin
            r_mem_rd_en         <= 1'b0;
            r_rd_data[r_grant]  <= mem.rd_data;
            r_rd_valid[r_grant] <= 1'b1;
            r_state             <= RESP;
          end
        end
        RESP: begin
          r_rd_valid <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem.rd_en   = r_mem_rd_en;
  assign mem.wr_en   = r_mem_wr_en;
  assign mem.addr    = r_mem_addr;
  assign mem.wr_data = r_mem_wr_data;
  assign p0.rd_data  = r_rd_data[P_CPU];
  assign p0.rd_valid = r_rd_valid[P_CPU];
  assign p1.rd_data  = r_rd_data[P_DBG];
  assign p1.rd_valid = r_rd_valid[P_DBG];
  assign wr_ovf      = w_ovf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RAM responder, a transaction-level model
// (expected read data per port, expected memory write sequence) checked every
// cycle, and literal expectations for latency, ordering and overflow.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] wr_ovf;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) p0_if ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) p1_if ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) mem_if ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .p0     (p0_if),
    .p1     (p1_if),
    .mem    (mem_if),
    .wr_ovf (wr_ovf)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment RAM and model RAM ----------------
  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;

  logic [31:0] env_ram [logic [15:0]];
  logic [31:0] mdl_ram [logic [15:0]];
  int          lat = 2;

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic logic [31:0] env_read(input logic [15:0] a);
    return env_ram.exists(a) ? env_ram[a] : dflt(a);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [15:0] a);
    return mdl_ram.exists(a) ? mdl_ram[a] : dflt(a);
  endfunction

  logic [15:0] ra;
  int          rsp_cyc = 0;
  int          rsp_cnt = 0;

  // RAM read responder: rd_valid arrives 'lat' cycles after rd_en is first seen.
  initial begin
    mem_if.rd_valid = 1'b0;
    mem_if.rd_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_if.rd_en && !rst) begin
        ra = mem_if.addr;
        repeat (lat) @(negedge clk);
        mem_if.rd_data  = env_read(ra);
        mem_if.rd_valid = 1'b1;
        rsp_cyc = cyc;
        rsp_cnt++;
        @(negedge clk);
        mem_if.rd_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_if.wr_en) env_ram[mem_if.addr] = mem_if.wr_data;
  end

  // ---------------- model state and per-cycle compare ----------------
  wr_t         exp_wr [$];
  logic [31:0] exp_rd0 [$];
  logic [31:0] exp_rd1 [$];
  int          order [$];
  int          wr_log [$];
  int          wr_cnt = 0;
  int          vcnt [2] = '{0, 0};
  int          last_v_cyc [2] = '{0, 0};
  logic [31:0] last_data [2] = '{32'h0, 32'h0};
  logic [1:0]  prev_rdv = 2'b00;
  logic        prev_mrd = 1'b0;
  int          rd_issue_cyc = 0;
  logic [15:0] rd_issue_addr = '0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      logic [1:0]  rdv;
      logic [31:0] e;
      wr_t         w;
      rdv = {p1_if.rd_valid, p0_if.rd_valid};
      chk("rd_wr_exclusive", 64'(mem_if.rd_en && mem_if.wr_en), 64'(0));
      chk("wr_expected", 64'(mem_if.wr_en && exp_wr.size() == 0), 64'(0));
      if (mem_if.rd_en && !prev_mrd) begin
        rd_issue_cyc  = cyc;
        rd_issue_addr = mem_if.addr;
      end
      if (mem_if.wr_en && exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        chk("mem_wr_addr", 64'(mem_if.addr), 64'(w.a));
        chk("mem_wr_data", 64'(mem_if.wr_data), 64'(w.d));
      end
      if (mem_if.wr_en) begin
        wr_cnt++;
        wr_log.push_back(cyc);
      end
      chk("p0_valid_pending", 64'(rdv[0] && exp_rd0.size() == 0), 64'(0));
      chk("p1_valid_pending", 64'(rdv[1] && exp_rd1.size() == 0), 64'(0));
      chk("p0_valid_strobe", 64'(rdv[0] && prev_rdv[0]), 64'(0));
      chk("p1_valid_strobe", 64'(rdv[1] && prev_rdv[1]), 64'(0));
      if (rdv[0]) begin
        vcnt[0]++; last_v_cyc[0] = cyc; last_data[0] = p0_if.rd_data; order.push_back(0);
        if (exp_rd0.size() > 0) begin
          e = exp_rd0.pop_front();
          chk("p0_rd_data", 64'(p0_if.rd_data), 64'(e));
        end
      end else begin
        chk("p0_rd_data_hold", 64'(p0_if.rd_data), 64'(last_data[0]));
      end
      if (rdv[1]) begin
        vcnt[1]++; last_v_cyc[1] = cyc; last_data[1] = p1_if.rd_data; order.push_back(1);
        if (exp_rd1.size() > 0) begin
          e = exp_rd1.pop_front();
          chk("p1_rd_data", 64'(p1_if.rd_data), 64'(e));
        end
      end else begin
        chk("p1_rd_data_hold", 64'(p1_if.rd_data), 64'(last_data[1]));
      end
      prev_rdv = rdv;
      prev_mrd = mem_if.rd_en;
    end else begin
      prev_rdv = 2'b00;
      prev_mrd = 1'b0;
    end
  end

  // ---------------- requester tasks ----------------
  task automatic do_read(input int p, input logic [15:0] a);
    bit seen;
    seen = 1'b0;
    if (p == 0) begin
      exp_rd0.push_back(mdl_read(a));
      p0_if.addr = a; p0_if.rd_en = 1'b1;
    end else begin
      exp_rd1.push_back(mdl_read(a));
      p1_if.addr = a; p1_if.rd_en = 1'b1;
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (p == 0) ? p0_if.rd_valid : p1_if.rd_valid;
    end
    chk((p == 0) ? "p0_read_done" : "p1_read_done", 64'(seen), 64'(1));
    @(posedge clk); #1;
    if (p == 0) p0_if.rd_en = 1'b0;
    else        p1_if.rd_en = 1'b0;
  endtask

  task automatic do_write(input int p, input logic [15:0] a, input logic [31:0] d, input bit drop);
    if (p == 0) begin
      p0_if.addr = a; p0_if.wr_data = d; p0_if.wr_en = 1'b1;
    end else begin
      p1_if.addr = a; p1_if.wr_data = d; p1_if.wr_en = 1'b1;
    end
    if (!drop) begin
      wr_t w;
      w.a = a; w.d = d;
      exp_wr.push_back(w);
      mdl_ram[a] = d;
    end
    @(posedge clk); #1;
    if (p == 0) p0_if.wr_en = 1'b0;
    else        p1_if.wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout at t=%0t", $time);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  int t0;
  int wc0;
  int vc0;
  int rc0;
  bit got;
  int exp_order [8];

  initial begin
    p0_if.rd_en = 1'b0; p0_if.wr_en = 1'b0; p0_if.addr = '0; p0_if.wr_data = '0;
    p1_if.rd_en = 1'b0; p1_if.wr_en = 1'b0; p1_if.addr = '0; p1_if.wr_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_rd_en",   64'(mem_if.rd_en),   64'(0));
    chk("rst_mem_wr_en",   64'(mem_if.wr_en),   64'(0));
    chk("rst_mem_addr",    64'(mem_if.addr),    64'(0));
    chk("rst_mem_wr_data", 64'(mem_if.wr_data), 64'(0));
    chk("rst_p0_rd_valid", 64'(p0_if.rd_valid), 64'(0));
    chk("rst_p1_rd_valid", 64'(p1_if.rd_valid), 64'(0));
    chk("rst_p0_rd_data",  64'(p0_if.rd_data),  64'(0));
    chk("rst_wr_ovf",      64'(wr_ovf),         64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: uncontended p0 read, RAM answers 2 cycles after mem_rd_en
    env_ram[16'h0010] = 32'hDEADBEEF;
    mdl_ram[16'h0010] = 32'hDEADBEEF;
    lat = 2;
    t0  = cyc;
    vc0 = vcnt[1];
    do_read(0, 16'h0010);
    chk("t1_mem_rd_en_cycle", 64'(rd_issue_cyc),  64'(t0 + 1));
    chk("t1_mem_addr",        64'(rd_issue_addr), 64'(16'h0010));
    chk("t1_ram_resp_cycle",  64'(rsp_cyc),       64'(t0 + 3));
    chk("t1_p0_valid_cycle",  64'(last_v_cyc[0]), 64'(t0 + 4));
    chk("t1_p0_rd_data",      64'(last_data[0]),  64'(32'hDEADBEEF));
    chk("t1_p1_no_valid",     64'(vcnt[1]),       64'(vc0));
    repeat (2) @(posedge clk);
    #1;

    // 2: posted write then read of the same address on p0
    t0 = cyc;
    wr_log.delete();
    do_write(0, 16'h0040, 32'h12345678, 1'b0);
    do_read(0, 16'h0040);
    chk("t2_wr_count",       64'(wr_log.size()),  64'(1));
    chk("t2_wr_cycle",       64'(wr_log[0]),      64'(t0 + 2));
    chk("t2_rd_issue_cycle", 64'(rd_issue_cyc),   64'(t0 + 4));
    chk("t2_p0_rd_data",     64'(last_data[0]),   64'(32'h12345678));
    repeat (2) @(posedge clk);
    #1;

    // 3: both ports hold rd_en for 4 reads each (p1 granted last beforehand)
    do_read(1, 16'h0300);
    repeat (2) @(posedge clk);
    #1;
    order.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) do_read(0, 16'(16'h0100 + i));
      end
      begin
        for (int i = 0; i < 4; i++) do_read(1, 16'(16'h0200 + i));
      end
    join
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    chk("t3_order_len", 64'(order.size()), 64'(8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_order_%0d", i), 64'((i < order.size()) ? order[i] : -1), 64'(exp_order[i]));
    repeat (2) @(posedge clk);
    #1;

    // 4: two back-to-back p1 writes while a p0 read stalls in RD
    lat = 8;
    wc0 = wr_cnt;
    fork
      do_read(0, 16'h0500);
      begin
        repeat (3) @(posedge clk);
        #1;
        do_write(1, 16'h0600, 32'hAAAA0001, 1'b0);
        do_write(1, 16'h0604, 32'hBBBB0002, 1'b1);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("t4_wr_ovf",      64'(wr_ovf),         64'(2'b10));
    chk("t4_wr_count",    64'(wr_cnt - wc0),   64'(1));
    chk("t4_wr_pending",  64'(exp_wr.size()),  64'(0));
    lat = 2;
    do_read(1, 16'h0604);
    chk("t4_dropped_wr_absent", 64'(last_data[1]), 64'({16'hC0DE, 16'h0604}));
    do_read(1, 16'h0600);
    chk("t4_kept_wr", 64'(last_data[1]), 64'(32'hAAAA0001));
    repeat (2) @(posedge clk);
    #1;

    // 5: reset while the read is outstanding in RD
    lat = 6;
    p0_if.addr = 16'h0700;
    p0_if.rd_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = mem_if.rd_en;
    end
    chk("t5_rd_issued", 64'(got), 64'(1));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_mem_rd_en_async", 64'(mem_if.rd_en), 64'(0));
    chk("t5_wr_ovf_cleared",  64'(wr_ovf),       64'(0));
    p0_if.rd_en  = 1'b0;
    last_data[0] = '0;
    last_data[1] = '0;
    vc0 = vcnt[0] + vcnt[1];
    rc0 = rsp_cnt;
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_late_ram_valid_seen", 64'(rsp_cnt - rc0),         64'(1));
    chk("t5_no_port_valid",       64'(vcnt[0] + vcnt[1]),     64'(vc0));
    chk("t5_mem_rd_en_idle",      64'(mem_if.rd_en),          64'(0));
    lat = 2;
    @(posedge clk);
    #1;

    // 6: second p0 write pulse lands on the cycle its first entry drains
    repeat (3) @(posedge clk);
    #1;
    t0  = cyc;
    wc0 = wr_cnt;
    wr_log.delete();
    do_write(0, 16'h0900, 32'h11110000, 1'b0);
    @(posedge clk);
    #1;
    do_write(0, 16'h0904, 32'h22220000, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_wr_ovf",     64'(wr_ovf),        64'(0));
    chk("t6_wr_count",   64'(wr_cnt - wc0),  64'(2));
    chk("t6_wr0_cycle",  64'((wr_log.size() > 0) ? wr_log[0] : -1), 64'(t0 + 2));
    chk("t6_wr1_cycle",  64'((wr_log.size() > 1) ? wr_log[1] : -1), 64'(t0 + 4));

    // Nothing left outstanding in the model
    chk("end_exp_wr_empty",  64'(exp_wr.size()),  64'(0));
    chk("end_exp_rd0_empty", 64'(exp_rd0.size()), 64'(0));
    chk("end_exp_rd1_empty", 64'(exp_rd1.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
